// File: rtl/tile_os_pkg.sv
// Shared types and helpers for the output-stationary systolic tile.
// State encoding, safe clog2 and default geometry constants.
package tile_os_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_I_F_BW = 8;
  localparam int DEF_W_BW   = 8;

  localparam int FLUSH_LEN = DEF_ROWS + DEF_COLS - 2;
  localparam int PROD_BW   = DEF_I_F_BW + DEF_W_BW;

  // clog2 that never returns 0, so one-entry indices still get a bit
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_tile_os_pe_mac.sv
// Single output-stationary PE: forwards fmap right and weight down,
// accumulating the signed product into a wrapping accumulator.
module pe_mac
  import tile_os_pkg::*;
#(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  input  logic              clr,
  input  logic [I_F_BW-1:0] a_in,
  input  logic [W_BW-1:0]   w_in,
  output logic [I_F_BW-1:0] a_out,
  output logic [W_BW-1:0]   w_out,
  output logic [ACC_BW-1:0] acc
);

  localparam int P_BW = I_F_BW + W_BW;

  logic signed [P_BW-1:0] a_x;
  logic signed [P_BW-1:0] w_x;
  logic signed [P_BW-1:0] prod;
  logic [ACC_BW-1:0]      prod_x;

  assign a_x    = $signed({{W_BW{a_in[I_F_BW-1]}}, a_in});
  assign w_x    = $signed({{I_F_BW{w_in[W_BW-1]}}, w_in});
  assign prod   = a_x * w_x;
  assign prod_x = {{(ACC_BW-P_BW){prod[P_BW-1]}}, prod};

  // pass-through registers and accumulator, frozen on stall steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else if (step_en) begin
      a_out <= a_in;
      w_out <= w_in;
      acc   <= acc + prod_x;
    end
  end

endmodule

// File: rtl/systolic_tile_os.sv
// ROWS x COLS output-stationary systolic tile with built-in sequencer:
// load K beats, flush the skew, then drain one result row per beat.
module systolic_tile_os
  import tile_os_pkg::*;
#(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 256,
  parameter int K_W    = $clog2(K_MAX + 1),
  parameter int R_W    = clog2_safe(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [K_W-1:0]         i_k_len,
  input  logic                   i_relu,
  output logic                   o_busy,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [I_F_BW*ROWS-1:0] i_fmap,
  input  logic [W_BW*COLS-1:0]   i_weight,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [ACC_BW*COLS-1:0] o_res_data,
  output logic [R_W-1:0]         o_res_row,
  output logic                   o_done
);

  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int FL_W    = clog2_safe(FLUSH_N + 1);

  state_t state;
  state_t state_nx;

  logic [K_W-1:0]  k_len_q;
  logic [K_W-1:0]  k_cnt;
  logic [K_W-1:0]  k_clamp;
  logic [FL_W-1:0] fl_cnt;
  logic [R_W-1:0]  row_cnt;
  logic            relu_q;

  logic start_acc;
  logic hs;
  logic rd_hs;
  logic step;
  logic last_beat;
  logic last_fl;
  logic last_row;

  logic [I_F_BW-1:0] a_h   [ROWS][COLS+1];
  logic [W_BW-1:0]   w_v   [ROWS+1][COLS];
  logic [ACC_BW-1:0] acc_g [ROWS][COLS];
  logic [ACC_BW-1:0] v;

  assign k_clamp = (i_k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : i_k_len;

  assign start_acc = (state == IDLE) && i_start;
  assign hs        = (state == LOAD) && i_in_valid;
  assign rd_hs     = (state == DRAIN) && i_res_ready;
  assign step      = hs || (state == FLUSH);

  assign last_beat = (k_cnt == k_len_q - K_W'(1));
  assign last_fl   = (fl_cnt == FL_W'(FLUSH_N - 1));
  assign last_row  = (row_cnt == R_W'(ROWS - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = (k_clamp == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (hs && last_beat) begin
          state_nx = (FLUSH_N == 0) ? DRAIN : FLUSH;
        end
      end
      FLUSH: begin
        if (last_fl) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_hs && last_row) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake and status outputs
  always_comb begin
    o_busy      = 1'b0;
    o_in_ready  = 1'b0;
    o_res_valid = 1'b0;
    o_done      = 1'b0;
    unique case (1'b1)
      (state == LOAD): begin
        o_busy     = 1'b1;
        o_in_ready = 1'b1;
      end
      (state == FLUSH): o_busy = 1'b1;
      (state == DRAIN): begin
        o_busy      = 1'b1;
        o_res_valid = 1'b1;
      end
      (state == DONE): o_done = 1'b1;
      default: ;
    endcase
  end

  // job parameters and beat / flush / row counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q <= '0;
      relu_q  <= 1'b0;
      k_cnt   <= '0;
      fl_cnt  <= '0;
      row_cnt <= '0;
    end else if (start_acc) begin
      k_len_q <= k_clamp;
      relu_q  <= i_relu;
      k_cnt   <= '0;
      fl_cnt  <= '0;
      row_cnt <= '0;
    end else begin
      if (hs) begin
        k_cnt <= k_cnt + K_W'(1);
      end
      if (state == FLUSH) begin
        fl_cnt <= fl_cnt + FL_W'(1);
      end
      if (rd_hs) begin
        row_cnt <= last_row ? '0 : row_cnt + R_W'(1);
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_fsk
    logic [I_F_BW-1:0] lane;
    logic [I_F_BW-1:0] a_unused;

    assign lane     = (state == LOAD) ? i_fmap[r*I_F_BW +: I_F_BW] : '0;
    assign a_unused = a_h[r][COLS];

    if (r == 0) begin : g_d
      assign a_h[r][0] = lane;
    end else begin : g_sr
      logic [I_F_BW-1:0] sr [r];

      // fmap lane delayed by r steps
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (start_acc) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (step) begin
          sr[0] <= lane;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end

      assign a_h[r][0] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wsk
    logic [W_BW-1:0] lane;
    logic [W_BW-1:0] w_unused;

    assign lane     = (state == LOAD) ? i_weight[c*W_BW +: W_BW] : '0;
    assign w_unused = w_v[ROWS][c];

    if (c == 0) begin : g_d
      assign w_v[0][c] = lane;
    end else begin : g_sr
      logic [W_BW-1:0] sr [c];

      // weight lane delayed by c steps
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (start_acc) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (step) begin
          sr[0] <= lane;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end

      assign w_v[0][c] = sr[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe_mac #(
        .I_F_BW (I_F_BW),
        .W_BW   (W_BW),
        .ACC_BW (ACC_BW)
      ) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step),
        .clr     (start_acc),
        .a_in    (a_h[r][c]),
        .w_in    (w_v[r][c]),
        .a_out   (a_h[r][c+1]),
        .w_out   (w_v[r+1][c]),
        .acc     (acc_g[r][c])
      );
    end
  end

  // drain mux: select current row, clamp negatives when relu is set
  always_comb begin
    o_res_data = '0;
    o_res_row  = '0;
    v          = '0;
    if (state == DRAIN) begin
      o_res_row = row_cnt;
      for (int c = 0; c < COLS; c++) begin
        v = acc_g[row_cnt][c];
        if (relu_q && v[ACC_BW-1]) begin
          v = '0;
        end
        o_res_data[c*ACC_BW +: ACC_BW] = v;
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile_os.sv
// Self-checking bench for systolic_tile_os: matrix-product model,
// per-cycle drain compare, directed jobs, reset abort and backpressure.
`timescale 1ns/1ps
module tb_systolic_tile_os;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int IB   = 8;
  localparam int WB   = 8;
  localparam int AB   = 32;
  localparam int KM   = 256;
  localparam int KW   = 9;
  localparam int RW   = 2;
  localparam int FL   = ROWS + COLS - 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic [KW-1:0]      i_k_len;
  logic               i_relu;
  logic               o_busy;
  logic               i_in_valid;
  logic               o_in_ready;
  logic [IB*ROWS-1:0] i_fmap;
  logic [WB*COLS-1:0] i_weight;
  logic               o_res_valid;
  logic               i_res_ready;
  logic [AB*COLS-1:0] o_res_data;
  logic [RW-1:0]      o_res_row;
  logic               o_done;

  always #5 clk = ~clk;

  systolic_tile_os dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_k_len     (i_k_len),
    .i_relu      (i_relu),
    .o_busy      (o_busy),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_fmap      (i_fmap),
    .i_weight    (i_weight),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_data  (o_res_data),
    .o_res_row   (o_res_row),
    .o_done      (o_done)
  );

  int checks   = 0;
  int failures = 0;

  int f_s [KM][ROWS];
  int w_s [KM][COLS];
  int exp_acc [ROWS][COLS];
  bit exp_relu   = 1'b0;
  int exp_row    = 0;
  bit chk_on     = 1'b0;
  bit seen_ready = 1'b0;
  int done_cnt   = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // expected matrix: plain sum of products over the accepted beats
  task automatic model(input int k);
    int s;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        s = 0;
        for (int b = 0; b < k; b++) s += f_s[b][r] * w_s[b][c];
        exp_acc[r][c] = s;
      end
    end
  endtask

  function automatic logic [127:0] row_vec(input int r);
    logic [127:0] vv;
    int e;
    vv = '0;
    for (int c = 0; c < COLS; c++) begin
      e = exp_acc[r][c];
      if (exp_relu && e < 0) e = 0;
      vv[c*AB +: AB] = e;
    end
    return vv;
  endfunction

  task automatic fill_const(input int fv, input int wv);
    for (int b = 0; b < KM; b++) begin
      for (int r = 0; r < ROWS; r++) f_s[b][r] = fv;
      for (int c = 0; c < COLS; c++) w_s[b][c] = wv;
    end
  endtask

  // one compare process: every drained row against the model
  always @(negedge clk) begin
    if (chk_on) begin
      if (o_in_ready) seen_ready = 1'b1;
      if (o_done) done_cnt++;
      if (o_res_valid) begin
        if (exp_row >= ROWS) begin
          chk("extra_row", exp_row, ROWS - 1);
        end else begin
          chk("res_row", o_res_row, exp_row);
          chk("res_data", o_res_data, row_vec(exp_row));
          if (i_res_ready) exp_row++;
        end
      end
    end
  end

  task automatic run_job(input int k, input bit relu, input bit gaps,
                         input bit bp);
    int ke;
    int b;
    int n;
    int guard;
    bit hs;
    ke = (k > KM) ? KM : k;
    model(ke);
    exp_relu   = relu;
    exp_row    = 0;
    done_cnt   = 0;
    seen_ready = 1'b0;
    chk_on     = 1'b1;
    i_start = 1'b1;
    i_k_len = k[KW-1:0];
    i_relu  = relu;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_relu  = 1'b0;
    chk("busy_after_start", o_busy, 1);
    b = 0;
    guard = 0;
    while (b < ke && guard < 4000) begin
      i_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_start    = (b == 1);
      i_k_len    = 1;
      for (int r = 0; r < ROWS; r++) i_fmap[r*IB +: IB] = f_s[b][r][IB-1:0];
      for (int c = 0; c < COLS; c++) i_weight[c*WB +: WB] = w_s[b][c][WB-1:0];
      @(negedge clk);
      hs = i_in_valid && o_in_ready;
      @(posedge clk); #1;
      if (hs) b++;
      guard++;
    end
    i_in_valid = 1'b0;
    i_start    = 1'b0;
    i_fmap     = '0;
    i_weight   = '0;
    if (guard >= 4000) chk("load_timeout", b, ke);
    if (ke > 0) begin
      n = 0;
      while (!o_res_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("latency", n, FL);
    end
    guard = 0;
    while (!o_done && guard < 500) begin
      i_res_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    i_res_ready = 1'b0;
    chk("done_seen", o_done, 1);
    chk("busy_at_done", o_busy, 0);
    i_start = 1'b1;
    i_k_len = 3;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("start_in_done_ignored", {o_busy, o_in_ready}, 0);
    @(posedge clk); #1;
    chk("rows_drained", exp_row, ROWS);
    chk("done_pulses", done_cnt, 1);
    if (ke == 0) chk("no_in_ready", seen_ready, 0);
    chk_on = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_k_len     = '0;
    i_relu      = 1'b0;
    i_in_valid  = 1'b0;
    i_fmap      = '0;
    i_weight    = '0;
    i_res_ready = 1'b0;
    #3;
    chk("reset_ctrl", {o_busy, o_in_ready, o_res_valid, o_done}, 0);
    chk("reset_data", o_res_data, 0);
    chk("reset_row", o_res_row, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // all ones times all twos, one beat
    fill_const(1, 2);
    model(1);
    chk("pin_t1_00", exp_acc[0][0], 2);
    chk("pin_t1_33", exp_acc[3][3], 2);
    run_job(1, 1'b0, 1'b0, 1'b0);

    // unit fmap vectors select weight rows
    fill_const(0, 0);
    for (int b = 0; b < 4; b++) begin
      f_s[b][b] = 1;
      for (int c = 0; c < COLS; c++) w_s[b][c] = 10 * b + c;
    end
    model(4);
    chk("pin_t2_21", exp_acc[2][1], 21);
    chk("pin_t2_33", exp_acc[3][3], 33);
    run_job(4, 1'b0, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b1, 1'b0);
    run_job(4, 1'b0, 1'b0, 1'b1);
    run_job(4, 1'b0, 1'b1, 1'b1);

    // full-depth extremes and relu clamp
    fill_const(-128, -128);
    model(256);
    chk("pin_t3_max", exp_acc[1][2], 4194304);
    run_job(256, 1'b0, 1'b0, 1'b0);
    fill_const(-128, 127);
    model(256);
    chk("pin_t3_raw", exp_acc[0][0], -4161536);
    exp_relu = 1'b1;
    chk("pin_t3_relu", row_vec(0), 0);
    run_job(256, 1'b1, 1'b0, 1'b0);

    // k_len above K_MAX runs K_MAX beats
    fill_const(1, 1);
    model(256);
    chk("pin_clamp", exp_acc[2][2], 256);
    run_job(300, 1'b0, 1'b0, 1'b0);

    // empty job drains zeros
    run_job(0, 1'b0, 1'b0, 1'b0);

    // abort a k=8 job after two beats
    fill_const(5, 7);
    i_start = 1'b1;
    i_k_len = 8;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_in_valid = 1'b1;
    i_fmap = {4{8'd5}};
    i_weight = {4{8'd7}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_load", {o_busy, o_in_ready}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {o_busy, o_in_ready, o_res_valid, o_done}, 0);
    chk("abort_data", o_res_data, 0);
    chk("abort_row", o_res_row, 0);
    i_in_valid = 1'b0;
    i_fmap = '0;
    i_weight = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mixed-sign job after the abort, relu on
    fill_const(0, 0);
    f_s[0][0] = 1;  f_s[0][1] = -1; f_s[0][2] = 2;  f_s[0][3] = -3;
    f_s[1][0] = 4;  f_s[1][1] = 5;  f_s[1][2] = -6; f_s[1][3] = 7;
    w_s[0][0] = 3;  w_s[0][1] = -2; w_s[0][2] = 1;  w_s[0][3] = 0;
    w_s[1][0] = -1; w_s[1][1] = 2;  w_s[1][2] = 2;  w_s[1][3] = -5;
    model(2);
    chk("pin_mix_00", exp_acc[0][0], -1);
    chk("pin_mix_11", exp_acc[1][1], 12);
    run_job(2, 1'b1, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_tile_os.md
Name: systolic_tile_os

Overview:
- Parametrised ROWS x COLS output-stationary systolic tile with an integrated sequencer.
- Replaces the fixed 5x5 tile, its separate enable FSM and its external accumulator.
- Accepts K beats of feature-map column and weight row vectors over a valid/ready handshake, skews them internally and accumulates in every PE.
- Flushes the array, then drains the ROWS x COLS result one row per beat under backpressure, with optional ReLU.

Parameters:
I_F_BW, 8, signed feature-map element width
W_BW, 8, signed weight element width
ACC_BW, 32, signed accumulator / result width (must be >= I_F_BW+W_BW)
ROWS, 4, PE rows (feature-map lanes)
COLS, 4, PE columns (weight lanes)
K_MAX, 256, maximum reduction depth per job
K_W, $clog2(K_MAX+1), width of k length field
R_W, $clog2(ROWS) (min 1), row index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_start  in  1  job start pulse; accepted only in IDLE
i_k_len  in  K_W  reduction depth, sampled with i_start; values > K_MAX clamp to K_MAX
i_relu  in  1  ReLU enable, sampled with i_start
o_busy  out  1  high from the cycle after start acceptance until o_done
i_in_valid  in  1  i_fmap / i_weight beat valid
o_in_ready  out  1  beat accepted when valid & ready
i_fmap  in  I_F_BW*ROWS  lane r at bits [r*I_F_BW +: I_F_BW]
i_weight  in  W_BW*COLS  lane c at bits [c*W_BW +: W_BW]
o_res_valid  out  1  result row valid
i_res_ready  in  1  result row consumed when valid & ready
o_res_data  out  ACC_BW*COLS  row o_res_row; column c at [c*ACC_BW +: ACC_BW]
o_res_row  out  R_W  row index of o_res_data
o_done  out  1  one-cycle pulse after the last result row is consumed

Behaviour:
- Reset (async, any state):
  - FSM to IDLE.
  - All accumulators, skew registers and counters cleared.
  - o_busy, o_in_ready, o_res_valid and o_done are 0; o_res_data and o_res_row are 0.
- FSM states are IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE:
  - On i_start, latch k_len and relu and clear every accumulator.
  - Next state is LOAD, or DRAIN if k_len == 0.
  - i_start in any other state is ignored.
- LOAD:
  - o_in_ready = 1.
  - Each handshake is one "step".
  - The beat counter advances per step; after step k_len the FSM goes to FLUSH.
  - Cycles without valid are stall cycles: the whole array and all skew registers hold.
- FLUSH:
  - Exactly ROWS+COLS-2 steps, one per cycle, with zeros injected at all inputs; o_in_ready = 0.
  - If ROWS+COLS-2 == 0, go straight to DRAIN.
- Step operation:
  - Skew: fmap lane r is delayed r steps and weight lane c is delayed c steps.
  - PE(r,c) passes fmap right and weight down through registers.
  - Each PE does acc <= acc + sext(a*w), a signed I_F_BW x W_BW product sign-extended to ACC_BW.
  - Overflow wraps (modulo 2^ACC_BW).
  - Final acc(r,c) = sum over k of fmap_k[r]*weight_k[c].
- DRAIN:
  - o_res_valid = 1 with o_res_row = 0..ROWS-1 in order.
  - o_res_data is acc of that row; if relu is set, negative entries output as 0.
  - Data and row are held stable until handshake.
  - The row index advances on handshake; after row ROWS-1 the FSM goes to DONE.
- DONE:
  - o_done = 1 for one cycle, o_busy = 0 in the same cycle, then IDLE.
  - A new i_start is accepted the following cycle.
- Latency:
  - o_in_ready rises the cycle after start acceptance.
  - The first o_res_valid occurs ROWS+COLS-2 cycles after the last input handshake, plus 1 for the FSM transition.
- i_res_ready held high gives ROWS consecutive beats.
- Simultaneous events:
  - i_start while in DONE is ignored.
  - In LOAD, a valid that is low on the final counted beat simply stalls.

Decomposition:
- Package tile_os_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN, DONE);
  - a clog2-safe helper function;
  - localparams FLUSH_LEN = ROWS+COLS-2 and PROD_BW = I_F_BW+W_BW.
- One sub-module, pe_mac:
  - registered fmap/weight pass-through and an ACC_BW accumulator;
  - inputs step_en and clr.
- The top level holds the FSM, counters, skew shift registers and the drain multiplexer, and uses generate loops for the PE grid.

Test Plan:
1. Defaults, k_len=1, all fmap=1, all weight=2, ready=1 -> rows 0..3 each {2,2,2,2}; o_done pulses once.
2. k_len=4, fmap_k = unit vector e_k, weight_k[c] = 10*k+c -> row r = {10r, 10r+1, 10r+2, 10r+3}. Repeat with random i_in_valid gaps -> identical results.
3. k_len=256, fmap all -128, weight all -128 -> every entry 4194304. Then fmap -128, weight 127 with i_relu=1 -> every entry 0.
4. k_len=0 -> no o_in_ready ever; 4 rows of zeros, then o_done.
5. Random i_res_ready backpressure during DRAIN -> o_res_data/o_res_row stable while stalled; rows in order 0..3; no row lost or repeated.
6. rst_n asserted mid-LOAD (beat 2 of 8) -> outputs 0 immediately. A new job after reset -> results independent of the aborted job; i_start during busy is ignored.
